recon_dma_desc_arbiter: RTL and testbench

//  Shares one DMA read-descriptor channel between PORTS requesters (reconfiguration controller, host loader, etc.).

---
 rtl/recon_dma_desc_arbiter_pkg.sv | 22 ++
 rtl/recon_dma_desc_arbiter_if.sv | 55 +++++
 rtl/recon_dma_desc_arbiter_rr_arbiter.sv | 34 +++
 rtl/recon_dma_desc_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_recon_dma_desc_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/recon_dma_desc_arbiter_pkg.sv
// Shared definitions for the DMA read-descriptor arbiter: FSM encoding, DMA status codes
// and a small wrap-around increment helper used by the round-robin pointer.
package recon_dma_desc_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Completion error codes reported by the DMA read engine.
    localparam logic [3:0] DMA_ERR_OK      = 4'h0;
    localparam logic [3:0] DMA_ERR_DECODE  = 4'h1;
    localparam logic [3:0] DMA_ERR_SLAVE   = 4'h2;
    localparam logic [3:0] DMA_ERR_TIMEOUT = 4'h3;

    localparam int CNT_WIDTH = 4;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/recon_dma_desc_arbiter_if.sv
// Requester-side descriptor/status bus plus DMA-engine-side descriptor/status bus of the arbiter.
// master: the arbiter's view; slave: the surrounding requesters and DMA engine.
interface recon_dma_desc_arbiter_if #(
    parameter int PORTS      = 2,
    parameter int ADDR_WIDTH = 34,
    parameter int LEN_WIDTH  = 20,
    parameter int TAG_WIDTH  = 8
);
    localparam int SEL_WIDTH   = $clog2(PORTS);
    localparam int M_TAG_WIDTH = TAG_WIDTH + SEL_WIDTH;

    logic [PORTS*ADDR_WIDTH-1:0] s_desc_addr;
    logic [PORTS*LEN_WIDTH-1:0]  s_desc_len;
    logic [PORTS*TAG_WIDTH-1:0]  s_desc_tag;
    logic [PORTS-1:0]            s_desc_valid;
    logic [PORTS-1:0]            s_desc_ready;

    logic [ADDR_WIDTH-1:0]       m_desc_addr;
    logic [LEN_WIDTH-1:0]        m_desc_len;
    logic [M_TAG_WIDTH-1:0]      m_desc_tag;
    logic                        m_desc_valid;
    logic                        m_desc_ready;

    logic [M_TAG_WIDTH-1:0]      s_status_tag;
    logic [3:0]                  s_status_error;
    logic                        s_status_valid;

    logic [PORTS*TAG_WIDTH-1:0]  m_status_tag;
    logic [PORTS*4-1:0]          m_status_error;
    logic [PORTS-1:0]            m_status_valid;

    logic [PORTS*4-1:0]          outstanding;
    logic                        status_tag_err;

    modport master (
        input  s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
        output s_desc_ready,
        output m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        input  m_desc_ready,
        input  s_status_tag, s_status_error, s_status_valid,
        output m_status_tag, m_status_error, m_status_valid,
        output outstanding, status_tag_err
    );

    modport slave (
        output s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
        input  s_desc_ready,
        input  m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        output m_desc_ready,
        output s_status_tag, s_status_error, s_status_valid,
        input  m_status_tag, m_status_error, m_status_valid,
        input  outstanding, status_tag_err
    );

endinterface

// File: rtl/recon_dma_desc_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requesting port at or after ptr, wrapping at PORTS.
module recon_dma_desc_arbiter_rr_arbiter #(
    parameter int PORTS     = 2,
    parameter int SEL_WIDTH = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]     req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 any_grant
);

    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] cand;

    // Scan from the farthest offset down so the nearest requester past ptr wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
            if (sum >= (SEL_WIDTH+1)'(PORTS)) begin
                sum = sum - (SEL_WIDTH+1)'(PORTS);
            end
            cand = sum[SEL_WIDTH-1:0];
            if (req[cand]) begin
                grant     = cand;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recon_dma_desc_arbiter.sv
// Shares one DMA read-descriptor channel between PORTS requesters with round-robin grant,
// per-port outstanding limits and completion routing back to the issuing requester.
module recon_dma_desc_arbiter
    import recon_dma_desc_arbiter_pkg::*;
#(
    parameter int PORTS           = 2,
    parameter int ADDR_WIDTH      = 34,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    recon_dma_desc_arbiter_if.master  bus
);

    localparam int SEL_WIDTH   = $clog2(PORTS);
    localparam int M_TAG_WIDTH = TAG_WIDTH + SEL_WIDTH;

    arb_state_t state_q, state_d;

    logic [SEL_WIDTH-1:0]   rr_ptr_q;
    logic [SEL_WIDTH-1:0]   grant_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [M_TAG_WIDTH-1:0] mtag_q;

    logic [CNT_WIDTH-1:0]   cnt_q   [PORTS];
    logic [TAG_WIDTH-1:0]   stag_q  [PORTS];
    logic [3:0]             serr_q  [PORTS];
    logic [PORTS-1:0]       svalid_q;
    logic                   tag_err_q;

    logic [PORTS-1:0]       eligible;
    logic [SEL_WIDTH-1:0]   arb_grant;
    logic                   any_grant;
    logic [PORTS-1:0]       desc_ready;
    logic                   accept;
    logic                   issue_done;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic [TAG_WIDTH-1:0]   sel_tag;

    logic [SEL_WIDTH-1:0]   st_idx;
    logic [PORTS-1:0]       inc;
    logic [PORTS-1:0]       dec;
    logic                   st_bad;

    // Requests are masked during reset so no accept strobe can leak out while rst_n is low.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = rst_n && bus.s_desc_valid[i] &&
                          (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    recon_dma_desc_arbiter_rr_arbiter #(
        .PORTS     (PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_tag  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (arb_grant == SEL_WIDTH'(i)) begin
                sel_addr = bus.s_desc_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = bus.s_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_tag  = bus.s_desc_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        desc_ready = '0;
        accept     = 1'b0;
        issue_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    desc_ready[arb_grant] = 1'b1;
                    accept                = 1'b1;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_desc_ready) begin
                    issue_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            mtag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= arb_grant;
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                mtag_q  <= {arb_grant, sel_tag};
            end
            if (issue_done) begin
                rr_ptr_q <= SEL_WIDTH'(wrap_inc(32'(grant_q), PORTS));
            end
        end
    end

    // A completion is only honoured for a port that actually has something in flight.
    always_comb begin
        st_idx = bus.s_status_tag[M_TAG_WIDTH-1 -: SEL_WIDTH];
        inc    = '0;
        dec    = '0;
        for (int i = 0; i < PORTS; i++) begin
            inc[i] = issue_done && (grant_q == SEL_WIDTH'(i));
            dec[i] = bus.s_status_valid && (st_idx == SEL_WIDTH'(i)) && (cnt_q[i] != '0);
        end
        st_bad = bus.s_status_valid && (dec == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORTS; i++) begin
                cnt_q[i]  <= '0;
                stag_q[i] <= '0;
                serr_q[i] <= '0;
            end
            svalid_q  <= '0;
            tag_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                case ({inc[i], dec[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
                if (dec[i]) begin
                    stag_q[i] <= bus.s_status_tag[TAG_WIDTH-1:0];
                    serr_q[i] <= bus.s_status_error;
                end
            end
            svalid_q  <= dec;
            tag_err_q <= st_bad;
        end
    end

    always_comb begin
        bus.m_status_tag   = '0;
        bus.m_status_error = '0;
        bus.outstanding    = '0;
        for (int i = 0; i < PORTS; i++) begin
            bus.m_status_tag[i*TAG_WIDTH +: TAG_WIDTH] = stag_q[i];
            bus.m_status_error[i*4 +: 4]               = serr_q[i];
            bus.outstanding[i*4 +: 4]                  = cnt_q[i];
        end
    end

    assign bus.s_desc_ready   = desc_ready;
    assign bus.m_desc_valid   = (state_q == ISSUE);
    assign bus.m_desc_addr    = addr_q;
    assign bus.m_desc_len     = len_q;
    assign bus.m_desc_tag     = mtag_q;
    assign bus.m_status_valid = svalid_q;
    assign bus.status_tag_err = tag_err_q;

endmodule

// File: tb/tb_recon_dma_desc_arbiter.sv
// Bench for recon_dma_desc_arbiter (PORTS=3): directed vector table, hand-written corner
// sequences and a randomized run checked against a cycle-level behavioural model.
module tb_recon_dma_desc_arbiter;

    localparam int PORTS = 3;
    localparam int AW    = 34;
    localparam int LW    = 20;
    localparam int TW    = 8;
    localparam int MAXO  = 4;
    localparam int SW    = 2;
    localparam int MTW   = TW + SW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recon_dma_desc_arbiter_if #(.PORTS(PORTS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus ();

    recon_dma_desc_arbiter #(
        .PORTS(PORTS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model state ----------------
    int             m_cnt [PORTS];
    int             m_ptr;
    bit             m_busy;
    int             m_g;
    logic [AW-1:0]  m_addr;
    logic [LW-1:0]  m_len;
    logic [MTW-1:0] m_tag;
    logic [PORTS-1:0] m_sv;
    logic [TW-1:0]  m_stag [PORTS];
    logic [3:0]     m_serr [PORTS];
    bit             m_terr;
    logic [PORTS-1:0] last_ready;

    task automatic model_reset();
        for (int i = 0; i < PORTS; i++) begin
            m_cnt[i] = 0; m_stag[i] = '0; m_serr[i] = '0;
        end
        m_ptr = 0; m_busy = 0; m_g = 0; m_addr = '0; m_len = '0; m_tag = '0;
        m_sv = '0; m_terr = 0;
    endtask

    task automatic drive(input logic [PORTS-1:0] v, input logic mr, input logic stv,
                         input logic [MTW-1:0] stg, input logic [3:0] ser);
        bus.s_desc_valid   = v;
        bus.m_desc_ready   = mr;
        bus.s_status_valid = stv;
        bus.s_status_tag   = stg;
        bus.s_status_error = ser;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [TW-1:0] t);
        bus.s_desc_addr[i*AW +: AW] = a;
        bus.s_desc_len[i*LW +: LW]  = l;
        bus.s_desc_tag[i*TW +: TW]  = t;
    endtask

    // Compare this cycle's outputs with the model, then advance the model over the clock edge.
    task automatic model_cycle();
        logic [PORTS-1:0] er;
        logic [PORTS-1:0] nsv;
        logic [SW-1:0]    idx;
        int g;
        int dn;
        bit nterr;
        er = '0; g = -1;
        if (!m_busy) begin
            for (int k = 0; k < PORTS; k++) begin
                int p;
                p = (m_ptr + k) % PORTS;
                if (g < 0 && bus.s_desc_valid[p] && m_cnt[p] < MAXO) g = p;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        last_ready = bus.s_desc_ready;
        chk("s_desc_ready", 64'(bus.s_desc_ready), 64'(er));
        chk("m_desc_valid", 64'(bus.m_desc_valid), 64'(m_busy));
        if (m_busy) begin
            chk("m_desc_addr", 64'(bus.m_desc_addr), 64'(m_addr));
            chk("m_desc_len", 64'(bus.m_desc_len), 64'(m_len));
            chk("m_desc_tag", 64'(bus.m_desc_tag), 64'(m_tag));
        end
        chk("m_status_valid", 64'(bus.m_status_valid), 64'(m_sv));
        chk("status_tag_err", 64'(bus.status_tag_err), 64'(m_terr));
        for (int i = 0; i < PORTS; i++) begin
            chk($sformatf("outstanding%0d", i), 64'(bus.outstanding[i*4 +: 4]), 64'(m_cnt[i]));
            if (m_sv[i]) begin
                chk($sformatf("m_status_tag%0d", i), 64'(bus.m_status_tag[i*TW +: TW]), 64'(m_stag[i]));
                chk($sformatf("m_status_err%0d", i), 64'(bus.m_status_error[i*4 +: 4]), 64'(m_serr[i]));
            end
        end
        nsv = '0; nterr = 0; dn = -1;
        if (bus.s_status_valid) begin
            idx = bus.s_status_tag[MTW-1 -: SW];
            if (int'(idx) < PORTS && m_cnt[idx] > 0) begin
                dn = int'(idx);
                nsv[idx] = 1'b1;
                m_stag[idx] = bus.s_status_tag[TW-1:0];
                m_serr[idx] = bus.s_status_error;
            end else begin
                nterr = 1;
            end
        end
        if (m_busy) begin
            if (bus.m_desc_ready) begin
                m_cnt[m_g]++;
                m_ptr = (m_g + 1) % PORTS;
                m_busy = 0;
            end
        end else if (g >= 0) begin
            m_busy = 1; m_g = g;
            m_addr = bus.s_desc_addr[g*AW +: AW];
            m_len  = bus.s_desc_len[g*LW +: LW];
            m_tag  = {SW'(g), bus.s_desc_tag[g*TW +: TW]};
        end
        if (dn >= 0) m_cnt[dn]--;
        m_sv = nsv; m_terr = nterr;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_desc_valid", 64'(bus.m_desc_valid), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_m_status_valid", 64'(bus.m_status_valid), 64'd0);
        chk("rst_status_tag_err", 64'(bus.status_tag_err), 64'd0);
        chk("rst_s_desc_ready", 64'(bus.s_desc_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]  vld;
        logic        mrdy;
        logic        stv;
        logic [9:0]  stag;
        logic [2:0]  e_rdy;
        logic        e_mvld;
        logic [9:0]  e_mtag;
        logic [11:0] e_out;
        logic [2:0]  e_svld;
        logic        e_terr;
    } row_t;

    row_t tbl [18];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n0, n1;
        logic [PORTS-1:0] rsum;

        //              vld    mr  stv stag     e_rdy  mv  e_mtag   e_out    e_svld terr
        tbl[0]  = '{3'b000, 0, 0, 10'h000, 3'b000, 0, 10'h000, 12'h000, 3'b000, 0};
        tbl[1]  = '{3'b001, 0, 0, 10'h000, 3'b001, 0, 10'h000, 12'h000, 3'b000, 0};
        tbl[2]  = '{3'b000, 1, 0, 10'h000, 3'b000, 1, 10'h005, 12'h000, 3'b000, 0};
        tbl[3]  = '{3'b000, 0, 1, 10'h005, 3'b000, 0, 10'h000, 12'h001, 3'b000, 0};
        tbl[4]  = '{3'b000, 0, 0, 10'h000, 3'b000, 0, 10'h000, 12'h000, 3'b001, 0};
        tbl[5]  = '{3'b011, 1, 0, 10'h000, 3'b010, 0, 10'h000, 12'h000, 3'b000, 0};
        tbl[6]  = '{3'b011, 1, 0, 10'h000, 3'b000, 1, 10'h111, 12'h000, 3'b000, 0};
        tbl[7]  = '{3'b011, 1, 0, 10'h000, 3'b001, 0, 10'h000, 12'h010, 3'b000, 0};
        tbl[8]  = '{3'b011, 1, 0, 10'h000, 3'b000, 1, 10'h005, 12'h010, 3'b000, 0};
        tbl[9]  = '{3'b011, 1, 0, 10'h000, 3'b010, 0, 10'h000, 12'h011, 3'b000, 0};
        tbl[10] = '{3'b000, 1, 0, 10'h000, 3'b000, 1, 10'h111, 12'h011, 3'b000, 0};
        tbl[11] = '{3'b000, 0, 1, 10'h300, 3'b000, 0, 10'h000, 12'h021, 3'b000, 0};
        tbl[12] = '{3'b000, 0, 1, 10'h200, 3'b000, 0, 10'h000, 12'h021, 3'b000, 1};
        tbl[13] = '{3'b000, 0, 1, 10'h105, 3'b000, 0, 10'h000, 12'h021, 3'b000, 1};
        tbl[14] = '{3'b000, 0, 0, 10'h000, 3'b000, 0, 10'h000, 12'h011, 3'b010, 0};
        tbl[15] = '{3'b001, 0, 0, 10'h000, 3'b001, 0, 10'h000, 12'h011, 3'b000, 0};
        tbl[16] = '{3'b000, 1, 1, 10'h005, 3'b000, 1, 10'h005, 12'h011, 3'b000, 0};
        tbl[17] = '{3'b000, 0, 0, 10'h000, 3'b000, 0, 10'h000, 12'h011, 3'b001, 0};

        set_port(0, 34'h1000, 20'd256, 8'h05);
        set_port(1, 34'h2000, 20'd128, 8'h11);
        set_port(2, 34'h3000, 20'd64,  8'h22);
        do_reset();

        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].vld, tbl[r].mrdy, tbl[r].stv, tbl[r].stag, 4'h0);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 64'(bus.s_desc_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_mvalid", r), 64'(bus.m_desc_valid), 64'(tbl[r].e_mvld));
            if (tbl[r].e_mvld) begin
                chk($sformatf("tbl%0d_mtag", r), 64'(bus.m_desc_tag), 64'(tbl[r].e_mtag));
                if (tbl[r].e_mtag == 10'h005)
                    chk($sformatf("tbl%0d_maddr", r), 64'(bus.m_desc_addr), 64'h1000);
            end
            chk($sformatf("tbl%0d_outstanding", r), 64'(bus.outstanding), 64'(tbl[r].e_out));
            chk($sformatf("tbl%0d_svalid", r), 64'(bus.m_status_valid), 64'(tbl[r].e_svld));
            chk($sformatf("tbl%0d_tagerr", r), 64'(bus.status_tag_err), 64'(tbl[r].e_terr));
            if (tbl[r].e_svld[0])
                chk($sformatf("tbl%0d_stag0", r), 64'(bus.m_status_tag[7:0]), 64'h05);
            @(posedge clk);
            #1;
        end

        // Port 0 saturates at MAX_OUTSTANDING while port 1 keeps being served.
        do_reset();
        n0 = 0;
        for (int c = 0; c < 10; c++) begin
            drive(3'b001, 1'b1, 1'b0, '0, '0);
            step();
            if (last_ready[0]) n0++;
        end
        chk("sat_grants0", 64'(n0), 64'd4);
        chk("sat_outstanding0", 64'(bus.outstanding[3:0]), 64'd4);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 4; c++) begin
            drive(3'b011, 1'b1, 1'b0, '0, '0);
            step();
            if (last_ready[0]) n0++;
            if (last_ready[1]) n1++;
        end
        chk("sat_blocked0", 64'(n0), 64'd0);
        chk("sat_grants1", 64'(n1), 64'd2);
        drive(3'b001, 1'b1, 1'b1, 10'h005, 4'h2);
        step();
        n0 = 0;
        for (int c = 0; c < 3; c++) begin
            drive(3'b001, 1'b1, 1'b0, '0, '0);
            step();
            if (last_ready[0]) n0++;
        end
        chk("sat_regrant0", 64'(n0), 64'd1);

        // Engine back-pressure: descriptor held stable and no new accepts.
        drive(3'b010, 1'b0, 1'b0, '0, '0);
        step();
        rsum = '0;
        for (int c = 0; c < 10; c++) begin
            set_port(1, 34'(c * 16 + 7), 20'(c), 8'(c + 100));
            drive(3'b011, 1'b0, 1'b0, '0, '0);
            step();
            rsum |= last_ready;
        end
        chk("stall_no_ready", 64'(rsum), 64'd0);
        drive(3'b000, 1'b1, 1'b0, '0, '0);
        step();

        // Reset in the middle of an issue: valid and counters drop without a clock edge.
        drive(3'b010, 1'b0, 1'b0, '0, '0);
        step();
        chk("pre_rst_mvalid", 64'(bus.m_desc_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mvalid", 64'(bus.m_desc_valid), 64'd0);
        chk("async_rst_outstanding", 64'(bus.outstanding), 64'd0);
        @(negedge clk);
        chk("rst_hold_ready", 64'(bus.s_desc_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(3'b111, 1'b1, 1'b0, '0, '0);
        step();
        chk("post_rst_grant", 64'(last_ready), 64'b001);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < PORTS; i++)
                set_port(i, 34'({$urandom(), $urandom()}), 20'($urandom()), 8'($urandom()));
            drive(3'($urandom()) | 3'($urandom()),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0),
                  {2'($urandom_range(0, 3)), 8'($urandom())},
                  4'($urandom()));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
